spi_rx_word: RTL and testbench

- SPI slave receiver on the FPGA. It deserialises fixed-width, MSB-first words from an external SPI master (mode-0 style: master shifts on sclk falling edge, slave samples on rising edge, ncs active-low framing).
- Runs entirely in the system clk domain by oversampling sclk/mosi/ncs; it is not clocked by sclk.
- Delivers each completed word through a one-entry valid/ready output register, with framing-error and overrun indications.
- It is the far end of the existing 11-bit voltage link, used for loopback verification and for Pi-to-FPGA traffic.

---
 rtl/spi_rx_pkg.sv | 12 +
 rtl/sync_edge.sv | 38 +++
 rtl/spi_rx_word.sv | 167 ++++++++++++++++
 tb/tb_spi_rx_word.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI word receiver and the matching 11-bit voltage-link transmitter.
package spi_rx_pkg;

    localparam int unsigned VOLTAGE_W = 11;

    typedef enum logic [1:0] {
        WAIT_HIGH,
        IDLE,
        SHIFT
    } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser with registered edge flags; sync is delayed one extra
// flop so that it lines up with rise/fall for every instance.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    input  logic rst_val,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic              sync_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= {STAGES{rst_val}};
            sync_q  <= rst_val;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], async_in};
            sync_q  <= chain_q[STAGES-1];
            rise_q  <= chain_q[STAGES-1] & ~sync_q;
            fall_q  <= ~chain_q[STAGES-1] & sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_rx_word.sv
// Oversampled mode-0 SPI slave receiver: deserialises MSB-first words and hands
// them out through a one-entry valid/ready register with frame-error and overrun pulses.
module spi_rx_word
    import spi_rx_pkg::*;
#(
    parameter int unsigned WIDTH       = VOLTAGE_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ncs,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned SH_W   = WIDTH - 1;
    localparam int unsigned SETTLE = SYNC_STAGES + 1;

    logic sclk_rise;
    logic ncs_s;
    logic ncs_rise;
    logic ncs_fall;
    logic mosi_s;
    logic unused_sclk_s;
    logic unused_sclk_fall;
    logic unused_mosi_rise;
    logic unused_mosi_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk      (clk),
        .reset    (reset),
        .async_in (sclk),
        .rst_val  (1'b0),
        .sync     (unused_sclk_s),
        .rise     (sclk_rise),
        .fall     (unused_sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk      (clk),
        .reset    (reset),
        .async_in (ncs),
        .rst_val  (1'b1),
        .sync     (ncs_s),
        .rise     (ncs_rise),
        .fall     (ncs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk      (clk),
        .reset    (reset),
        .async_in (mosi),
        .rst_val  (1'b0),
        .sync     (mosi_s),
        .rise     (unused_mosi_rise),
        .fall     (unused_mosi_fall)
    );

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SH_W-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             commit_c;
    logic [WIDTH-1:0] word_c;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state, shift/commit and handshake logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        commit_c = 1'b0;
        word_c   = {shift_q, mosi_s};

        case (state_q)
            // The counter doubles as a settle timer so a low ncs still inside the
            // synchroniser after reset is not mistaken for a fresh frame start.
            WAIT_HIGH: begin
                if (ncs_s) begin
                    if (cnt_q >= CNT_W'(SETTLE)) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            IDLE: begin
                if (ncs_fall) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[SH_W-2:0], mosi_s};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                if (sclk_rise && (cnt_q == CNT_W'(WIDTH - 1))) begin
                    commit_c = 1'b1;
                    state_d  = WAIT_HIGH;
                end else if (ncs_rise) begin
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = WAIT_HIGH;
            end
        endcase

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (commit_c) begin
            if (!valid_q || ready) begin
                data_d  = word_c;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_spi_rx_word.sv
// Scoreboard bench for spi_rx_word: stimulus pushes expected events, a negedge
// monitor pops them on every data handshake, frame_err or overrun pulse.
module tb_spi_rx_word;
    import spi_rx_pkg::*;

    localparam int unsigned W  = VOLTAGE_W;
    localparam int unsigned SS = 2;
    localparam int K_DATA = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         sclk  = 1'b0;
    logic         mosi  = 1'b0;
    logic         ncs   = 1'b1;
    logic         ready = 1'b0;
    logic [W-1:0] data_out;
    logic         valid;
    logic         frame_err;
    logic         overrun;

    typedef struct {
        int           kind;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    spi_rx_word #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .mosi      (mosi),
        .ncs       (ncs),
        .ready     (ready),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void push(input int kind, input logic [W-1:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic observe(input int kind, input logic [W-1:0] d, input string name);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event data=%0h, required no event", name, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== d) begin
                n_fail++;
                $display("FAIL %s: actual kind=%0d data=%0h required kind=%0d data=%0h",
                         name, kind, d, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every output event must match the head of the expectation queue
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err === 1'b1) observe(K_FERR, '0, "frame_err");
            if (overrun === 1'b1)   observe(K_OVR, '0, "overrun");
            if (valid === 1'b1 && ready) observe(K_DATA, data_out, "data");
        end
    end

    // One sclk half-period of 4 clk; optional latency check and commit-cycle ready pulse
    task automatic sclk_phase(input logic lvl, input bit last_hi, input bit lat_chk, input bit cready);
        sclk = lvl;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #2;
            if (last_hi && cready) begin
                if (c == SS)     ready = 1'b1;
                if (c == SS + 1) ready = 1'b0;
            end
            if (last_hi && lat_chk) begin
                if (c == SS)     chk("latency_early", 32'(valid), 32'd0);
                if (c == SS + 1) chk("latency_valid", 32'(valid), 32'd1);
            end
        end
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int from, input int to,
                             input bit lat_chk, input bit cready);
        for (int i = from; i < to; i++) begin
            mosi = w[W-1-i];
            sclk_phase(1'b0, 1'b0, 1'b0, 1'b0);
            sclk_phase(1'b1, (i == W - 1), lat_chk, cready);
        end
    endtask

    task automatic idle_sclk(input int n);
        for (int i = 0; i < n; i++) begin
            sclk_phase(1'b1, 1'b0, 1'b0, 1'b0);
            sclk_phase(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic frame_end(input int extra);
        for (int i = 0; i < extra; i++) begin
            sclk_phase(1'b0, 1'b0, 1'b0, 1'b0);
            sclk_phase(1'b1, 1'b0, 1'b0, 1'b0);
        end
        sclk_phase(1'b0, 1'b0, 1'b0, 1'b0);
        ncs = 1'b1;
        idle_sclk(2);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input int extra, input bit lat_chk, input bit cready);
        ncs = 1'b0;
        send_bits(w, 0, W, lat_chk, cready);
        frame_end(extra);
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        @(posedge clk);
        #2;
        ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_data", 32'(data_out), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_ferr", 32'(frame_err), 32'd0);
        chk("reset_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #2;

        // Single word, consumer not ready, exact latency
        push(K_DATA, 11'h5A3);
        send_frame(11'h5A3, 0, 1'b1, 1'b0);
        chk("t1_data", 32'(data_out), 32'h5A3);
        repeat (10) @(posedge clk);
        #2;
        chk("t1_hold_valid", 32'(valid), 32'd1);
        chk("t1_hold_data", 32'(data_out), 32'h5A3);
        pulse_ready();
        chk("t1_valid_clr", 32'(valid), 32'd0);
        chk("t1_data_kept", 32'(data_out), 32'h5A3);

        // Back-to-back frames, consumer always ready
        ready = 1'b1;
        push(K_DATA, 11'h7FF);
        push(K_DATA, 11'h001);
        send_frame(11'h7FF, 0, 1'b0, 1'b0);
        send_frame(11'h001, 0, 1'b0, 1'b0);

        // Truncated frame then a good one
        push(K_FERR, '0);
        ncs = 1'b0;
        send_bits(11'h3C0, 0, 6, 1'b0, 1'b0);
        frame_end(0);
        push(K_DATA, 11'h2AB);
        send_frame(11'h2AB, 0, 1'b0, 1'b0);
        ready = 1'b0;

        // Overrun with a full output register
        push(K_OVR, '0);
        push(K_DATA, 11'h100);
        send_frame(11'h100, 0, 1'b0, 1'b0);
        send_frame(11'h200, 0, 1'b0, 1'b0);
        chk("t4_data_kept", 32'(data_out), 32'h100);
        chk("t4_valid", 32'(valid), 32'd1);
        pulse_ready();
        chk("t4_valid_clr", 32'(valid), 32'd0);

        // Consumer ready exactly in the second commit cycle: replace, no overrun
        push(K_DATA, 11'h100);
        push(K_DATA, 11'h200);
        send_frame(11'h100, 0, 1'b0, 1'b0);
        send_frame(11'h200, 0, 1'b0, 1'b1);
        chk("t4b_data", 32'(data_out), 32'h200);
        chk("t4b_valid", 32'(valid), 32'd1);
        pulse_ready();

        // sclk with ncs high, then trailing sclk edges after a full word
        idle_sclk(40);
        ready = 1'b1;
        push(K_DATA, 11'h0F0);
        send_frame(11'h0F0, 3, 1'b0, 1'b0);
        chk("t5_no_second", 32'(valid), 32'd0);
        ready = 1'b0;

        // Asynchronous reset mid-frame
        send_frame(11'h0AA, 0, 1'b0, 1'b0);
        chk("t6_pre_data", 32'(data_out), 32'h0AA);
        ncs = 1'b0;
        send_bits(11'h155, 0, 5, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_rst_data", 32'(data_out), 32'd0);
        chk("t6_rst_valid", 32'(valid), 32'd0);
        chk("t6_rst_ferr", 32'(frame_err), 32'd0);
        chk("t6_rst_ovr", 32'(overrun), 32'd0);
        repeat (2) @(posedge clk);
        #4;
        reset = 1'b0;
        @(posedge clk);
        #2;
        send_bits(11'h155, 5, W, 1'b0, 1'b0);
        frame_end(0);
        chk("t6_tail_ignored", 32'(valid), 32'd0);
        ready = 1'b1;
        push(K_DATA, 11'h155);
        send_frame(11'h155, 0, 1'b0, 1'b0);
        ready = 1'b0;

        repeat (20) @(posedge clk);
        #2;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
